// File: rtl/lc3_memory_io.sv
// LC-3 memory and memory-mapped I/O block.
// A 16-bit-wide RAM with registered, write-first reads shares the address space
// with four device registers: keyboard status/data (KBSR/KBDR) and display
// status/data (DSR/DDR). The keyboard and display ports use valid/ready handshakes.
module lc3_memory_io #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] mar,
    input  logic [15:0]              mdr,
    input  logic                     memwe,
    output logic [15:0]              memOut,
    input  logic                     kbd_valid,
    input  logic [7:0]               kbd_data,
    output logic                     kbd_ready,
    output logic                     disp_valid,
    output logic [7:0]               disp_data,
    input  logic                     disp_ready,
    output logic                     kbd_int
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    // Device registers live at the low ADDRESS_WIDTH bits of the LC-3 I/O page.
    localparam logic [ADDRESS_WIDTH-1:0] KBSR_ADDR = ADDRESS_WIDTH'(16'hFE00);
    localparam logic [ADDRESS_WIDTH-1:0] KBDR_ADDR = ADDRESS_WIDTH'(16'hFE02);
    localparam logic [ADDRESS_WIDTH-1:0] DSR_ADDR  = ADDRESS_WIDTH'(16'hFE04);
    localparam logic [ADDRESS_WIDTH-1:0] DDR_ADDR  = ADDRESS_WIDTH'(16'hFE06);

    logic [15:0] mem [DEPTH];

    logic        is_kbsr, is_kbdr, is_dsr, is_ddr, is_ram;
    logic        ram_we, kbd_accept, kbdr_read, ddr_write, disp_done;
    logic [15:0] ram_rdata;

    logic [15:0] mem_out_d,    mem_out_q;
    logic        kbd_flag_d,   kbd_flag_q;
    logic [7:0]  kbd_char_d,   kbd_char_q;
    logic        kbd_ie_d,     kbd_ie_q;
    logic        dsr_ready_d,  dsr_ready_q;
    logic        disp_valid_d, disp_valid_q;
    logic [7:0]  disp_data_d,  disp_data_q;

    assign is_kbsr = (mar == KBSR_ADDR);
    assign is_kbdr = (mar == KBDR_ADDR);
    assign is_dsr  = (mar == DSR_ADDR);
    assign is_ddr  = (mar == DDR_ADDR);
    assign is_ram  = ~(is_kbsr | is_kbdr | is_dsr | is_ddr);

    assign ram_we     = memwe & is_ram;
    assign kbd_accept = kbd_valid & ~kbd_flag_q;
    assign kbdr_read  = ~memwe & is_kbdr;
    assign ddr_write  = memwe & is_ddr;
    assign disp_done  = disp_valid_q & disp_ready;
    assign ram_rdata  = mem[mar];

    // RAM array write port; device-register addresses never reach the array.
    // NOTE: the RAM deliberately has no reset -- clearing 2^N words is not a
    // single-cycle operation and software must not rely on power-up contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[mar] <= mdr;
        end
    end

    // Read-data mux: device registers, else RAM with write-first bypass.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mem_out_d = 16'h0000;
        if (is_kbsr) begin
            mem_out_d = {kbd_flag_q, kbd_ie_q, 14'b0};
        end else if (is_kbdr) begin
            mem_out_d = {8'b0, kbd_char_q};
        end else if (is_dsr) begin
            mem_out_d = {dsr_ready_q, 15'b0};
        end else if (is_ddr) begin
            mem_out_d = 16'h0000;
        end else if (ram_we) begin
            mem_out_d = mdr;
        end else begin
            mem_out_d = ram_rdata;
        end
    end

    // Keyboard and display next-state logic.
    always_comb begin
        kbd_flag_d   = kbd_flag_q;
        kbd_char_d   = kbd_char_q;
        kbd_ie_d     = kbd_ie_q;
        dsr_ready_d  = dsr_ready_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;

        // An incoming character wins over a KBDR read that finds the flag clear,
        // so a character arriving on that edge is not lost.
        if (kbd_accept) begin
            kbd_char_d = kbd_data;
            kbd_flag_d = 1'b1;
        end else if (kbdr_read) begin
            kbd_flag_d = 1'b0;
        end

        if (memwe && is_kbsr) begin
            kbd_ie_d = mdr[14];
        end

        // A DDR write is taken only while the display is idle; a write that lands
        // on the handshake edge sees dsr_ready=0 and is dropped.
        if (ddr_write && dsr_ready_q) begin
            disp_data_d  = mdr[7:0];
            dsr_ready_d  = 1'b0;
            disp_valid_d = 1'b1;
        end else if (disp_done) begin
            disp_valid_d = 1'b0;
            dsr_ready_d  = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_out_q    <= 16'h0000;
            kbd_flag_q   <= 1'b0;
            kbd_char_q   <= 8'h00;
            kbd_ie_q     <= 1'b0;
            dsr_ready_q  <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            mem_out_q    <= mem_out_d;
            kbd_flag_q   <= kbd_flag_d;
            kbd_char_q   <= kbd_char_d;
            kbd_ie_q     <= kbd_ie_d;
            dsr_ready_q  <= dsr_ready_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign memOut     = mem_out_q;
    assign kbd_ready  = ~kbd_flag_q;
    assign kbd_int    = kbd_flag_q & kbd_ie_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

endmodule

// File: doc/lc3_memory_io.md
LC3_MEMORY_IO -- requirements
Module: lc3_memory_io

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, setting the RAM address width; the RAM depth SHALL be 2^ADDRESS_WIDTH words of 16 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port mar, input, ADDRESS_WIDTH bits: memory address from the processor.
REQ-005 SHALL have port mdr, input, 16 bits: write data from the processor.
REQ-006 SHALL have port memwe, input, 1 bit: write enable from the processor.
REQ-007 SHALL have port memOut, output, 16 bits: read data to the processor.
REQ-008 SHALL have port kbd_valid, input, 1 bit: keyboard character offered.
REQ-009 SHALL have port kbd_data, input, 8 bits: keyboard character.
REQ-010 SHALL have port kbd_ready, output, 1 bit: block can accept a character.
REQ-011 SHALL have port disp_valid, output, 1 bit: display character pending.
REQ-012 SHALL have port disp_data, output, 8 bits: display character.
REQ-013 SHALL have port disp_ready, input, 1 bit: display sink accepts the character.
REQ-014 SHALL have port kbd_int, output, 1 bit: keyboard interrupt request.

Function
REQ-015 SHALL decode device registers as the low ADDRESS_WIDTH bits of xFE00 (KBSR), xFE02 (KBDR), xFE04 (DSR) and xFE06 (DDR); every other address SHALL be RAM.
REQ-016 SHALL, on a rising edge with memwe=1 and a RAM address, write mdr into RAM[mar].
REQ-017 SHALL register memOut on every rising edge with the data at the mar sampled on that edge: one-cycle read latency.
REQ-018 SHALL return the new data on memOut when a RAM read and write hit the same address on the same edge (write-first).
REQ-019 SHALL NOT modify RAM on writes to device-register addresses.
REQ-020 SHALL read KBSR as {kbd_flag, kbd_ie, 14'b0}, KBDR as {8'b0, kbd_char}, DSR as {dsr_ready, 15'b0}, and DDR as 16'b0.
REQ-021 SHALL drive kbd_ready = ~kbd_flag combinationally.
REQ-022 SHALL, on an edge with kbd_valid=1 and kbd_ready=1, load kbd_char from kbd_data and set kbd_flag to 1.
REQ-023 SHALL clear kbd_flag on an edge with memwe=0 and mar=KBDR; no character is accepted on that edge because kbd_ready=0.
REQ-024 SHALL load kbd_ie from mdr[14] on a write to KBSR; writes to kbd_flag and writes to KBDR SHALL be ignored.
REQ-025 SHALL drive kbd_int = kbd_flag & kbd_ie.
REQ-026 SHALL, on a write to DDR with dsr_ready=1, load disp_data from mdr[7:0], clear dsr_ready and set disp_valid to 1.
REQ-027 SHALL drop a write to DDR with dsr_ready=0 and leave disp_data unchanged.
REQ-028 SHALL hold disp_valid and disp_data stable until an edge with disp_ready=1; on that edge disp_valid SHALL go to 0 and dsr_ready to 1.
REQ-029 SHALL ignore writes to DSR.
REQ-030 SHALL, when a display handshake and a DDR write occur on the same edge, drop the write (dsr_ready is sampled as 0) and complete the handshake.

Reset
REQ-031 SHALL, while reset=0, asynchronously force memOut=0, kbd_flag=0, kbd_char=0, kbd_ie=0, dsr_ready=1, disp_valid=0, disp_data=0; hence kbd_ready=1 and kbd_int=0.
REQ-032 SHALL NOT reset RAM contents.
REQ-033 SHALL abandon a pending keyboard character or display character when reset asserts mid-operation, with no handshake completing.

Verification
REQ-034 SHALL verify: write x1234 to x3000, then read x3000 -> memOut=x1234 one edge after the read address is presented.
REQ-035 SHALL verify: kbd_valid=1 with kbd_data=x41 -> kbd_ready falls, KBSR reads x8000, KBDR reads x0041, KBSR reads x0000 after the KBDR read.
REQ-036 SHALL verify: write x4000 to KBSR, then input a keyboard character -> kbd_int=1, and kbd_int=0 after the KBDR read.
REQ-037 SHALL verify: write x0058 to DDR with disp_ready=0 -> disp_valid=1 with disp_data=x58 and DSR reads x0000; a second DDR write of x0059 is dropped; disp_ready=1 -> disp_valid=0 and DSR reads x8000.
REQ-038 SHALL verify: same-edge write and read of x3001 -> new data on memOut; a write to xFE00 leaves RAM unchanged (check through an aliased RAM address when ADDRESS_WIDTH<16).
REQ-039 SHALL verify: reset=0 asserted while disp_valid=1 and kbd_flag=1 -> all outputs immediately take their REQ-031 reset values without waiting for a clock edge.
